// File: rtl/keypad_entry_sequencer_if.sv
// Handshake bundle between the keypad front end and its consumer.
// The master drives the raw key and control lines, and the slave (the sequencer) drives the digit outputs.
interface keypad_entry_sequencer_if #(
   parameter int PTR_W = 2
);
   logic [3:0]     key_code;
   logic           key_pressed;
   logic           consumer_ready;
   logic           flush;
   logic [3:0]     read_input_from;
   logic           read_input;
   logic [PTR_W:0] fifo_count;
   logic           overflow;

   modport master (
      output key_code, key_pressed, consumer_ready, flush,
      input  read_input_from, read_input, fifo_count, overflow
   );

   modport slave (
      input  key_code, key_pressed, consumer_ready, flush,
      output read_input_from, read_input, fifo_count, overflow
   );
endinterface

// File: rtl/keypad_entry_sequencer.sv
// Synchronises and debounces raw keypad input, then queues each accepted digit.
// The queued digits are drained as single-cycle strobes for cypher_detect.
module keypad_entry_sequencer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DEPTH           = 4,
   parameter int PTR_W           = 2
) (
   input logic                     clk,
   input logic                     reset,
   keypad_entry_sequencer_if.slave bus
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   logic             key_meta, key_sync;
   logic [3:0]       code_meta, code_sync;
   logic [1:0]       state;
   logic [CNT_W-1:0] counter;
   logic [3:0]       cand;
   logic [3:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             push, pop, push_ok, drop, full;

   always_ff @(posedge clk) begin
      if (!reset) begin
         key_meta  <= 1'b0;
         key_sync  <= 1'b0;
         code_meta <= 4'd0;
         code_sync <= 4'd0;
      end else begin
         key_meta  <= bus.key_pressed;
         key_sync  <= key_meta;
         code_meta <= bus.key_code;
         code_sync <= code_meta;
      end
   end

   // A digit is accepted only on the final stable cycle of a press, so holding a key never repeats
   always_comb begin
      push = 1'b0;
      if (state == PRESS_WAIT && key_sync && code_sync == cand && counter == CNT_MAX)
         push = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= '0;
         cand    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (key_sync && code_sync != 4'd0) begin
                  state   <= PRESS_WAIT;
                  counter <= '0;
                  cand    <= code_sync;
               end
            end
            PRESS_WAIT: begin
               if (!key_sync || code_sync != cand) state <= IDLE;
               else if (counter == CNT_MAX)        state <= PRESSED;
               else                                counter <= counter + 1'b1;
            end
            PRESSED: begin
               if (!key_sync) begin
                  state   <= RELEASE_WAIT;
                  counter <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (key_sync)                  state <= PRESSED;
               else if (counter == CNT_MAX)   state <= IDLE;
               else                           counter <= counter + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Gating pop on the current strobe forces a dead cycle between strobes.
   // Gating pop on a non-empty count means a push into an empty FIFO never falls through in the same cycle.
   always_comb begin
      full    = (count == FULL_COUNT);
      pop     = (count != '0) && bus.consumer_ready && !bus.read_input && !bus.flush;
      push_ok = push && !bus.flush && (!full || pop);
      drop    = push && !bus.flush && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (reset && push_ok)
         mem[wr_ptr] <= cand;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         bus.overflow <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         bus.overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) bus.overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.read_input_from <= 4'd0;
         bus.read_input      <= 1'b0;
      end else begin
         bus.read_input <= pop;
         if (pop) bus.read_input_from <= mem[rd_ptr];
      end
   end

   assign bus.fifo_count = count;
endmodule
